// File: rtl/regfile_pkg.sv
// Shared types and default sizing for the pipelined-datapath register file.
package regfile_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one bit per register, set on issue, cleared on
// writeback or by the clear engine's pointer, with two combinational lookups.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter  int DEPTH = DEF_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_set_en,
    input  logic [AW-1:0] i_set_addr,
    input  logic          i_clr_en,
    input  logic [AW-1:0] i_clr_addr,
    input  logic          i_wipe_en,
    input  logic [AW-1:0] i_wipe_addr,
    input  logic [AW-1:0] i_rd_addr1,
    input  logic [AW-1:0] i_rd_addr2,
    output logic          o_pend1,
    output logic          o_pend2
);

    logic [DEPTH-1:0] r_pend;
    logic [DEPTH-1:0] w_pend_next;

    // A newer issue outranks a writeback to the same entry; the clear engine outranks both.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_pend
            localparam logic [AW-1:0] IDX = AW'(gi);
            assign w_pend_next[gi] = (i_wipe_en && (i_wipe_addr == IDX)) ? 1'b0 :
                                     (i_set_en  && (i_set_addr  == IDX)) ? 1'b1 :
                                     (i_clr_en  && (i_clr_addr  == IDX)) ? 1'b0 :
                                     r_pend[gi];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_next;
        end
    end

    assign o_pend1 = r_pend[i_rd_addr1];
    assign o_pend2 = r_pend[i_rd_addr2];

endmodule

// File: rtl/reg_file_sb.sv
// Register file with 2 read / 1 write ports, pending-write scoreboard and a
// sequential clear engine. Define REGFILE_BYPASS_EN for write-through forwarding.
module reg_file_sb
    import regfile_pkg::*;
#(
    parameter  int WIDTH    = DEF_WIDTH,
    parameter  int DEPTH    = DEF_DEPTH,
    parameter  int ZERO_REG = 0,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             issue_en,
    input  logic [AW-1:0]    issue_addr,
    input  logic [AW-1:0]    rd_addr1,
    input  logic [AW-1:0]    rd_addr2,
    output logic [WIDTH-1:0] rd_data1,
    output logic [WIDTH-1:0] rd_data2,
    output logic             rd_pend1,
    output logic             rd_pend2,
    input  logic             clr_req,
    output logic             clr_busy,
    output logic             wr_accept
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    logic [WIDTH-1:0] r_regs [DEPTH];
    state_t           r_state;
    state_t           w_state_next;
    logic [AW-1:0]    r_ptr;
    logic [AW-1:0]    w_ptr_next;

    logic             w_idle;
    logic             w_clearing;
    logic             w_wr_zero;
    logic             w_iss_zero;
    logic             w_wr_do;
    logic             w_iss_do;
    logic [DEPTH-1:0] w_wen;
    logic [DEPTH-1:0] w_wipe;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_clearing = (r_state == ST_CLEAR);

    // Hardwired-zero entry swallows writes and issues before they reach any state.
    assign w_wr_zero  = (ZERO_REG != 0) && (wr_addr == '0);
    assign w_iss_zero = (ZERO_REG != 0) && (issue_addr == '0);
    assign w_wr_do    = wr_en && w_idle && !w_wr_zero;
    assign w_iss_do   = issue_en && w_idle && !w_iss_zero;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (clr_req) begin
                    w_state_next = ST_CLEAR;
                    w_ptr_next   = '0;
                end
            end
            ST_CLEAR: begin
                w_ptr_next = r_ptr + 1'b1;
                if (r_ptr == LAST_IDX) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_ptr_next   = '0;
            end
        endcase
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_sel
            localparam logic [AW-1:0] IDX = AW'(gi);
            assign w_wen[gi]  = w_wr_do && (wr_addr == IDX);
            assign w_wipe[gi] = w_clearing && (r_ptr == IDX);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wipe[i]) begin
                    r_regs[i] <= '0;
                end else if (w_wen[i]) begin
                    r_regs[i] <= wr_data;
                end
            end
        end
    end

    logic w_sb_pend1;
    logic w_sb_pend2;

    regfile_scoreboard #(
        .DEPTH(DEPTH)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (reset),
        .i_set_en   (w_iss_do),
        .i_set_addr (issue_addr),
        .i_clr_en   (w_wr_do),
        .i_clr_addr (wr_addr),
        .i_wipe_en  (w_clearing),
        .i_wipe_addr(r_ptr),
        .i_rd_addr1 (rd_addr1),
        .i_rd_addr2 (rd_addr2),
        .o_pend1    (w_sb_pend1),
        .o_pend2    (w_sb_pend2)
    );

    logic w_rd_zero1;
    logic w_rd_zero2;
    logic w_byp1;
    logic w_byp2;

    assign w_rd_zero1 = (ZERO_REG != 0) && (rd_addr1 == '0);
    assign w_rd_zero2 = (ZERO_REG != 0) && (rd_addr2 == '0);

`ifdef REGFILE_BYPASS_EN
    // Forward the accepted write so decode sees the value in the writeback cycle.
    assign w_byp1 = w_wr_do && (wr_addr == rd_addr1);
    assign w_byp2 = w_wr_do && (wr_addr == rd_addr2);
`else
    assign w_byp1 = 1'b0;
    assign w_byp2 = 1'b0;
`endif

    assign rd_data1 = w_rd_zero1 ? '0 : (w_byp1 ? wr_data : r_regs[rd_addr1]);
    assign rd_data2 = w_rd_zero2 ? '0 : (w_byp2 ? wr_data : r_regs[rd_addr2]);
    assign rd_pend1 = !w_rd_zero1 && !w_byp1 && w_sb_pend1;
    assign rd_pend2 = !w_rd_zero2 && !w_byp2 && w_sb_pend2;

    assign clr_busy  = w_clearing;
    assign wr_accept = wr_en && !w_clearing;

endmodule

// File: doc/reg_file_sb.md
Name: reg_file_sb

Overview:
Parametrised general-purpose register file for the next-generation (pipelined) datapath. Two combinational read ports and one write port, plus a pending-write scoreboard so decode can detect operands whose producer has not yet written back. A sequential clear engine zeroes the file on request without a full reset. Sits between decode (read/issue) and writeback (write).

Parameters:
WIDTH, 8, data width of each register
DEPTH, 4, number of registers (power of two, >=2)
ZERO_REG, 0, if 1 register 0 is hardwired to zero (reads 0, writes/issues to it ignored)
AW, $clog2(DEPTH), address width (derived localparam, not overridable)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
wr_en  in  1  writeback write strobe
wr_addr  in  AW  write address
wr_data  in  WIDTH  write data
issue_en  in  1  mark issue_addr as pending (producer issued)
issue_addr  in  AW  destination of issued instruction
rd_addr1  in  AW  read port 1 address
rd_addr2  in  AW  read port 2 address
rd_data1  out  WIDTH  read port 1 data
rd_data2  out  WIDTH  read port 2 data
rd_pend1  out  1  register at rd_addr1 has outstanding write
rd_pend2  out  1  register at rd_addr2 has outstanding write
clr_req  in  1  request sequential clear
clr_busy  out  1  clear engine active; writes/issues dropped
wr_accept  out  1  wr_en & ~clr_busy (combinational)

Behaviour:
- Reset (reset=0, async): all registers 0, all pending bits 0, FSM to IDLE, clear pointer 0; hence rd_data*=0, rd_pend*=0, clr_busy=0, wr_accept=0 when wr_en=0.
- Reads: combinational, zero latency; rd_dataN = regs[rd_addrN]; rd_pendN = pend[rd_addrN].
- Write: at posedge when wr_en=1 and FSM=IDLE: regs[wr_addr]<=wr_data, pend[wr_addr]<=0.
- Issue: at posedge when issue_en=1 and FSM=IDLE: pend[issue_addr]<=1.
- Same-cycle issue and write to same address: register takes wr_data, pend ends 1 (newer producer wins).
- Writes and issues to distinct addresses in same cycle both take effect.
- ZERO_REG=1: address 0 always reads 0 with rd_pend 0; writes/issues to 0 have no effect (wr_accept still follows formula).
- FSM states: IDLE, CLEAR.
  IDLE -> CLEAR on posedge with clr_req=1; ptr<=0.
  CLEAR: each cycle regs[ptr]<=0, pend[ptr]<=0, ptr<=ptr+1; at ptr==DEPTH-1 clear that entry and go to IDLE.
  Clear lasts exactly DEPTH cycles; clr_busy=1 iff state=CLEAR (registered).
  In CLEAR: wr_en/issue_en dropped (no state change), clr_req ignored; reads remain live and show partially cleared contents.
  clr_req held high in IDLE after completion restarts a new clear.
- Reset asserted mid-clear: immediate return to reset state; clear does not resume.

Optional Feature:
Macro REGFILE_BYPASS_EN. Defined: write-through forwarding; when wr_en=1, FSM=IDLE and wr_addr==rd_addrN (and not hardwired zero), rd_dataN=wr_data and rd_pendN=0 in the same cycle. Undefined: reads show stored value and stored pending bit until the next edge.

Decomposition:
- Package regfile_pkg: FSM state enum (ST_IDLE, ST_CLEAR), default WIDTH/DEPTH constants.
- Sub-module regfile_scoreboard: DEPTH pending bits with set (issue), clear (write), clear-all-by-pointer (clear engine) and two combinational lookup ports; top instantiates it once.

Test Plan:
- Reset, then read all addresses -> rd_data=0x00, rd_pend=0 everywhere, clr_busy=0.
- Write 0xA5 to r2; next cycle rd_addr1=2 -> rd_data1=0xA5; same cycle without bypass rd_data1=old 0x00, with REGFILE_BYPASS_EN rd_data1=0xA5.
- issue_en to r3, then read r3 -> rd_pend=1; write 0x3C to r3 -> pend 0 and data 0x3C; same-cycle issue+write r1 -> data written, pend=1.
- Fill r0..r3 with 0x11..0x44, pulse clr_req -> clr_busy high exactly 4 cycles, entries zeroed in order 0..3; wr_en of 0xFF to r1 during CLEAR -> wr_accept=0, r1 reads 0 afterwards.
- ZERO_REG=1: write 0x77 and issue to r0 -> r0 reads 0x00, rd_pend 0.
- Assert reset after 2 clear cycles -> clr_busy drops immediately, all registers 0, FSM IDLE, next write accepted.
